// File: rtl/stream_serializer_if.sv
// Parallel-word handshake plus serial-line bundle between a word producer and the serializer.
interface stream_serializer_if #(
  parameter int unsigned WIDTH = 11
);
  logic             word_valid;
  logic [WIDTH-1:0] word_data;
  logic             word_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             done;
  logic             busy;

  modport master (
    output word_valid, word_data,
    input  word_ready, ser_out, ser_valid, done, busy
  );

  modport slave (
    input  word_valid, word_data,
    output word_ready, ser_out, ser_valid, done, busy
  );
endinterface

// File: rtl/stream_serializer.sv
// Parallel-to-serial feeder: one holding word plus one shifting word, one bit per clock,
// seamless across back-to-back words.
module stream_serializer #(
  parameter int unsigned WIDTH     = 11,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input logic            clk,
  input logic            rst,
  stream_serializer_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic             hold_full, hold_full_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             ser_out, ser_out_d;
  logic             ser_valid, ser_valid_d;
  logic             done, done_d;
  logic             word_ready;
  logic             accept;
  logic             load;

  assign word_ready = !hold_full && !rst;
  assign accept     = bus.word_valid && word_ready;

  assign bus.word_ready = word_ready;
  assign bus.ser_out    = ser_out;
  assign bus.ser_valid  = ser_valid;
  assign bus.done       = done;
  assign bus.busy       = hold_full || (state == SHIFT);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      shreg     <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      hold_full <= hold_full_d;
      cnt       <= cnt_d;
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      done      <= done_d;
      if (accept) hold <= bus.word_data;
    end
  end

  // Next state; done is raised on the edge that puts the last bit on the line
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    hold_full_d = hold_full;
    cnt_d       = cnt;
    ser_out_d   = ser_out;
    ser_valid_d = ser_valid;
    done_d      = 1'b0;
    load        = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) begin
          load = 1'b1;
        end else begin
          ser_out_d   = IDLE_BIT;
          ser_valid_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          shreg_d   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          ser_out_d = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
          cnt_d     = cnt - CW'(1);
          done_d    = (cnt == CW'(1));
        end else if (hold_full) begin
          load = 1'b1;
        end else begin
          state_d     = IDLE;
          ser_valid_d = 1'b0;
          ser_out_d   = IDLE_BIT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d     = hold;
      cnt_d       = CW'(WIDTH - 1);
      hold_full_d = 1'b0;
      state_d     = SHIFT;
      ser_valid_d = 1'b1;
      ser_out_d   = MSB_FIRST ? hold[WIDTH-1] : hold[0];
    end

    // word_ready is low whenever load can fire, so these never coincide
    if (accept) hold_full_d = 1'b1;
  end
endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench: accepted words are expanded into expected bit queues, popped as serial bits appear.
module tb_stream_serializer;
  localparam int unsigned W = 11;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  int   acc_a  = 0;
  logic exp_a[$];
  logic exp_b[$];

  stream_serializer_if #(.WIDTH(W)) a_if ();
  stream_serializer_if #(.WIDTH(W)) b_if ();

  stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  stream_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));

  always #5 clk = ~clk;

  // Expected bit stream per accepted word, in the order each instance sends it
  always @(posedge clk) begin
    if (a_if.word_valid === 1'b1 && a_if.word_ready === 1'b1) begin
      acc_a = acc_a + 1;
      for (int i = int'(W) - 1; i >= 0; i--) exp_a.push_back(a_if.word_data[i]);
    end
    if (b_if.word_valid === 1'b1 && b_if.word_ready === 1'b1) begin
      for (int i = 0; i < int'(W); i++) exp_b.push_back(b_if.word_data[i]);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    a_if.word_valid = 1'b0; a_if.word_data = '0;
    b_if.word_valid = 1'b0; b_if.word_data = '0;
    repeat (3) @(negedge clk);
    total++; if (a_if.word_ready !== 1'b0) $display("FAIL reset_ready_in_rst: got %b want 0", a_if.word_ready); else passed++;
    total++; if (a_if.ser_out !== 1'b0) $display("FAIL reset_ser_out: got %b want 0", a_if.ser_out); else passed++;
    total++; if (a_if.ser_valid !== 1'b0) $display("FAIL reset_ser_valid: got %b want 0", a_if.ser_valid); else passed++;
    total++; if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", a_if.busy, a_if.done); else passed++;
    rst = 1'b0;
    #1;
    total++; if (a_if.word_ready !== 1'b1) $display("FAIL reset_ready_after: got %b want 1", a_if.word_ready); else passed++;
    total++; if (b_if.word_ready !== 1'b1 || b_if.busy !== 1'b0) $display("FAIL reset_b_ready_busy: got %b%b want 10", b_if.word_ready, b_if.busy); else passed++;
  endtask

  task automatic test_single();
    int   dones = 0;
    logic e;
    @(negedge clk);
    a_if.word_valid = 1'b1; a_if.word_data = 11'h2EC;
    @(negedge clk);
    a_if.word_valid = 1'b0;
    total++; if (a_if.word_ready !== 1'b0 || a_if.busy !== 1'b1) $display("FAIL single_accept: ready,busy got %b%b want 01", a_if.word_ready, a_if.busy); else passed++;
    for (int j = 1; j <= 25; j++) begin
      @(negedge clk);
      if (j <= 11) begin
        total++; if (a_if.ser_valid !== 1'b1) $display("FAIL single_valid%0d: got %b want 1", j, a_if.ser_valid); else passed++;
        e = (exp_a.size() > 0) ? exp_a.pop_front() : 1'bx;
        total++; if (a_if.ser_out !== e) $display("FAIL single_bit%0d: got %b want %b", j, a_if.ser_out, e); else passed++;
      end else begin
        total++; if (a_if.ser_valid !== 1'b0 || a_if.ser_out !== 1'b0) $display("FAIL single_idle%0d: valid,out got %b%b want 00", j, a_if.ser_valid, a_if.ser_out); else passed++;
      end
      total++; if (a_if.done !== (j == 11)) $display("FAIL single_done%0d: got %b want %b", j, a_if.done, (j == 11)); else passed++;
      if (j == 11 || j == 12) begin
        total++; if (a_if.busy !== (j == 11)) $display("FAIL single_busy%0d: got %b want %b", j, a_if.busy, (j == 11)); else passed++;
      end
      if (a_if.done === 1'b1) dones++;
    end
    total++; if (dones != 1) $display("FAIL single_done_count: got %0d want 1", dones); else passed++;
    total++; if (exp_a.size() != 0) $display("FAIL single_queue: got %0d left want 0", exp_a.size()); else passed++;
  endtask

  task automatic test_back_to_back();
    int   start = acc_a;
    int   run = 0, gaps = 0, dones = 0;
    bit   seen = 0, ended = 0;
    logic e;
    @(negedge clk);
    a_if.word_valid = 1'b1; a_if.word_data = 11'h2EC;
    @(negedge clk);
    a_if.word_data = 11'h7FF;
    total++; if (a_if.word_ready !== 1'b0) $display("FAIL b2b_ready_after_first: got %b want 0", a_if.word_ready); else passed++;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (acc_a - start >= 2) a_if.word_valid = 1'b0;
      if (j == 1) begin
        total++; if (a_if.word_ready !== 1'b1) $display("FAIL b2b_ready_transfer: got %b want 1", a_if.word_ready); else passed++;
      end
      if (j == 2) begin
        total++; if (a_if.word_ready !== 1'b0) $display("FAIL b2b_ready_after_second: got %b want 0", a_if.word_ready); else passed++;
      end
      if (a_if.ser_valid === 1'b1) begin
        if (ended) gaps++;
        seen = 1; run++;
        e = (exp_a.size() > 0) ? exp_a.pop_front() : 1'bx;
        total++; if (a_if.ser_out !== e) $display("FAIL b2b_bit%0d: got %b want %b", run, a_if.ser_out, e); else passed++;
      end else if (seen) begin
        ended = 1;
      end
      if (a_if.done === 1'b1) dones++;
    end
    total++; if (acc_a - start != 2) $display("FAIL b2b_accepts: got %0d want 2", acc_a - start); else passed++;
    total++; if (run != 22 || gaps != 0) $display("FAIL b2b_run: got %0d bits %0d gaps want 22 bits 0 gaps", run, gaps); else passed++;
    total++; if (dones != 2) $display("FAIL b2b_done_count: got %0d want 2", dones); else passed++;
  endtask

  task automatic test_lsb_first();
    logic e;
    @(negedge clk);
    b_if.word_valid = 1'b1; b_if.word_data = 11'h001;
    @(negedge clk);
    b_if.word_valid = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j <= 11) begin
        e = (exp_b.size() > 0) ? exp_b.pop_front() : 1'bx;
        total++; if (b_if.ser_valid !== 1'b1 || b_if.ser_out !== e) $display("FAIL lsb_bit%0d: valid,out got %b%b want 1%b", j, b_if.ser_valid, b_if.ser_out, e); else passed++;
        if (j == 1) begin
          total++; if (b_if.ser_out !== 1'b1) $display("FAIL lsb_first_bit: got %b want 1", b_if.ser_out); else passed++;
        end
      end else begin
        total++; if (b_if.ser_valid !== 1'b0) $display("FAIL lsb_end: got %b want 0", b_if.ser_valid); else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int start = acc_a;
    int bits = 0, late = 0;
    logic e;
    @(negedge clk);
    a_if.word_valid = 1'b1; a_if.word_data = 11'h5A5;
    @(negedge clk);
    a_if.word_data = 11'h3C3;
    for (int j = 0; j < 20 && bits < 4; j++) begin
      @(negedge clk);
      if (acc_a - start >= 2) a_if.word_valid = 1'b0;
      if (a_if.ser_valid === 1'b1) begin
        bits++;
        e = (exp_a.size() > 0) ? exp_a.pop_front() : 1'bx;
        total++; if (a_if.ser_out !== e) $display("FAIL mid_bit%0d: got %b want %b", bits, a_if.ser_out, e); else passed++;
      end
    end
    total++; if (bits != 4) $display("FAIL mid_bits_seen: got %0d want 4", bits); else passed++;
    total++; if (a_if.busy !== 1'b1 || a_if.word_ready !== 1'b0) $display("FAIL mid_hold_full: busy,ready got %b%b want 10", a_if.busy, a_if.word_ready); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (a_if.ser_out !== 1'b0 || a_if.ser_valid !== 1'b0) $display("FAIL mid_rst_line: out,valid got %b%b want 00", a_if.ser_out, a_if.ser_valid); else passed++;
    total++; if (a_if.busy !== 1'b0 || a_if.word_ready !== 1'b0 || a_if.done !== 1'b0) $display("FAIL mid_rst_status: busy,ready,done got %b%b%b want 000", a_if.busy, a_if.word_ready, a_if.done); else passed++;
    exp_a.delete();
    @(negedge clk);
    rst = 1'b0;
    a_if.word_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (a_if.ser_valid !== 1'b0 || a_if.ser_out !== 1'b0) late++;
    end
    total++; if (late != 0) $display("FAIL mid_after_release: got %0d active cycles want 0", late); else passed++;
    total++; if (exp_a.size() != 0) $display("FAIL mid_no_accept: got %0d queued bits want 0", exp_a.size()); else passed++;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stream_serializer.md
# stream_serializer

Upstream feeder for the serial sequence-detector FSM. Accepts parallel words through a valid/ready handshake, buffers one word while another shifts, and drives one bit per clock on a serial line with a qualifying valid. Serial outputs change only on the rising edge of `clk`, so they are stable when the detector samples them on the falling edge. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 11: bits per word; legal range 2–32.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 0: level driven on `ser_out` when no word is shifting.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `word_valid`  input  1  `word_data` holds a word to send.
- `word_data`  input  WIDTH  parallel word.
- `word_ready`  output  1  holding buffer can accept a word.
- `ser_out`  output  1  serial bit; connects to the detector's `in`.
- `ser_valid`  output  1  `ser_out` carries a payload bit.
- `done`  output  1  one-cycle pulse after the last bit of a word.
- `busy`  output  1  shifter or holding buffer is occupied.

## Operation
- Storage:
  - holding register `hold` with flag `hold_full`
  - shift register `shreg` (WIDTH bits)
  - bit counter `cnt` (ceil(log2 WIDTH) bits)
  - FSM with states IDLE and SHIFT.
- `word_ready = !hold_full && !rst`, decoded combinationally from `hold_full`. A word is accepted on a rising edge where `word_valid && word_ready`. The edge loads `hold` and sets `hold_full`.
- `word_data` is ignored when no word is accepted. A producer may hold `word_valid` high indefinitely.
- IDLE:
  - If `hold_full` is set: `shreg <= hold`, `cnt <= WIDTH-1`, clear `hold_full`, go to SHIFT, `ser_valid <= 1`, `ser_out <=` first bit.
  - Otherwise `ser_out` stays at IDLE_BIT and `ser_valid` stays 0.
- SHIFT, `cnt != 0`: shift `shreg` toward the output end, `cnt <= cnt-1`, `ser_out <=` next bit.
- SHIFT, `cnt == 0` (the last bit is currently on the line):
  - Pulse `done` for one cycle.
  - If `hold_full` is set, load the next word exactly as in IDLE and stay in SHIFT (seamless).
  - Otherwise go to IDLE with `ser_valid <= 0` and `ser_out <= IDLE_BIT`.
- Simultaneous events: if a word is accepted on the same edge that empties `hold`, both happen. This cannot occur because `word_ready` is 0 while `hold_full` is set. A word accepted while the shifter is busy waits in `hold`.
- `busy = hold_full || (state == SHIFT)`.
- Bit order: MSB_FIRST=1 sends `word_data[WIDTH-1]` down to `[0]`; MSB_FIRST=0 sends the reverse order.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, `hold_full` = 0, `cnt` = 0
  - `ser_out` = IDLE_BIT, `ser_valid` = 0, `done` = 0, `busy` = 0
  - `word_ready` = 0 while `rst` is high.
- Reset mid-word discards both the shifting word and the held word. No further payload bits appear. The first acceptance is possible on the first rising edge after `rst` falls.
- Latency:
  - Word accepted at edge k.
  - First bit valid from edge k+1 (shifter idle).
  - Bit i is valid from edge k+1+i.
  - `done` is high from edge k+WIDTH to edge k+WIDTH+1.
- Throughput is one bit per clock. With `hold` refilled before the last bit, `ser_valid` stays high continuously across words.
- `word_ready` falls on the accepting edge and rises on the edge where `hold` transfers to `shreg`.
- Every output changes only on a rising edge or on reset assertion. Each value is therefore stable at the falling edge used by the downstream detector.

## Test plan
- Reset with `word_valid` = 0 → `ser_out` = 0, `ser_valid` = 0, `word_ready` = 1 after `rst` falls, `busy` = 0.
- Send 0x2EC with WIDTH = 11, MSB_FIRST = 1 → `ser_out` = 0,1,0,1,1,1,0,1,1,0,0 on edges k+1..k+11; `done` high for exactly one cycle starting at edge k+11; `ser_valid` = 0 from k+12.
- Hold `word_valid` high with words 0x2EC then 0x7FF → 22 consecutive valid bits with no gap: the pattern above followed by eleven 1s. `word_ready` is low between acceptances.
- MSB_FIRST = 0, word 0x001 → first `ser_out` bit is 1, then ten 0s.
- Assert `rst` asynchronously after the 4th bit of a word while a second word sits in `hold` → `ser_out` = 0 and `ser_valid` = 0 immediately, `busy` = 0, and no bits from either word appear after release.
- Keep `word_valid` low after one word → `ser_out` = IDLE_BIT (0) indefinitely, `done` pulses exactly once, `busy` falls on the same edge as `ser_valid`.
